block_assembler: RTL and testbench
==================================

Name: block_assembler

Overview:
- Parametrised word-to-block packer placed between the AXI-Lite register write path and the AES core.
- Collects WORDS consecutive WORD_W-bit writes into one block and queues completed blocks in a BLK_DEPTH-entry FIFO.
- Presents queued blocks to the cipher over a valid/ready handshake.
- Adds over a single-block buffer: back-pressure, multi-block queueing, partial-block flush, overflow detection and occupancy reporting.

Parameters:
- WORD_W, 32: width of one input word.
- WORDS, 4: words per block, ≥2. Block width = WORD_W*WORDS.
- BLK_DEPTH, 4: completed-block FIFO entries, power of 2, ≥2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  input word strobe.
- wr_data  in  WORD_W  input word.
- in_ready  out  1  a word presented with wr_en is accepted this cycle.
- flush  in  1  discard the partially assembled block.
- out_data  out  WORD_W*WORDS  head-of-FIFO block.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer takes the head block.
- level  out  $clog2(BLK_DEPTH+1)  number of completed blocks queued.
- word_cnt  out  $clog2(WORDS)  words held in the partial block.
- overflow  out  1  sticky: a write was dropped.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset (reset low, async): word_cnt=0, level=0, FIFO pointers=0, out_valid=0, out_data=0, overflow=0, in_ready=1. Assembly and FIFO storage contents are don't-care.
- Word ordering: the first word of a block lands in out_data[WORD_W*WORDS-1 -: WORD_W] (MSB end); the last word lands in the LSBs.
- in_ready = !(word_cnt==WORDS-1 && level==BLK_DEPTH).
  - Depends only on registered state; there is no combinational path from out_ready.
  - When full, a same-cycle pop does not open the slot.
- Accept = wr_en && in_ready && !flush.
  - The word is written into the assembly register at position word_cnt.
  - word_cnt increments.
- Completion: accepting the word while word_cnt==WORDS-1 pushes the assembled block (including this word) into the FIFO at that edge and sets word_cnt=0.
- Latency: if the FIFO was empty, out_valid=1 and out_data=block in the cycle after the edge that accepted the last word (1 clk).
- Pop: out_valid && out_ready at an edge advances the read pointer and decrements level.
  - Simultaneous push and pop: level is unchanged and both pointers advance.
- out_data is the FIFO head. It is held stable while out_valid && !out_ready, and equals 0 when the FIFO is empty.
- Drop: wr_en && !in_ready && !flush discards the word and sets overflow=1 at that edge. word_cnt is unchanged.
- Flush: word_cnt=0 at the edge and the partial block is discarded.
  - Flush wins over wr_en in the same cycle: the word is discarded and overflow is not set.
  - Queued FIFO blocks are unaffected.
- overflow_clr clears overflow. A same-cycle drop wins, so overflow stays 1.
- Pointers wrap modulo BLK_DEPTH.
- level never exceeds BLK_DEPTH and never underflows; a pop when empty is ignored.
- Reset mid-block or with a non-empty FIFO: all state returns to reset values immediately, and every queued and partial word is lost.

Test Plan:
- Basic block: after reset, write 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on 4 consecutive clocks with out_ready=0 → next cycle out_valid=1, out_data=0x00112233_44556677_8899AABB_CCDDEEFF, level=1, word_cnt=0.
- Fill and back-pressure: hold out_ready=0 and write 4 full blocks, then 3 words of a 5th → level=4, word_cnt=3, in_ready=0. A 4th word is dropped: overflow=1, word_cnt=3. Pulse out_ready for 1 clk → level=3, in_ready=1 the following cycle. The 4th word is then accepted and level=4.
- Streaming: out_ready=1 and continuous writes of 0,1,2,…,15 → 4 blocks emerge in order ({0,1,2,3}, …, {12,13,14,15}). level never exceeds 1 and overflow stays 0.
- Flush: write 2 words (0xA, 0xB), then flush together with wr_en(0xC) → word_cnt=0, overflow=0. Next 4 words 1,2,3,4 produce out_data={1,2,3,4}.
- Async reset: with level=2 and word_cnt=2, drop reset mid-cycle → out_valid, level, word_cnt and overflow read 0 before the next clk edge. in_ready=1 after release.
- Overflow clear: set overflow via a drop, then assert overflow_clr alone → overflow=0. Assert overflow_clr together with a drop → overflow stays 1.

Source files
------------

// File: rtl/block_assembler.sv
// Word-to-block packer: collects WORDS writes into one block and queues
// finished blocks in a small FIFO that drains over a valid/ready handshake.
module block_assembler #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned WORDS     = 4,
    parameter int unsigned BLK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_en,
    input  logic [WORD_W-1:0]                wr_data,
    output logic                             in_ready,
    input  logic                             flush,
    output logic [WORD_W*WORDS-1:0]          out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(BLK_DEPTH+1)-1:0]   level,
    output logic [$clog2(WORDS)-1:0]         word_cnt,
    output logic                             overflow,
    input  logic                             overflow_clr
);
    localparam int unsigned BW = WORD_W * WORDS;
    localparam int unsigned LW = $clog2(BLK_DEPTH + 1);
    localparam int unsigned CW = $clog2(WORDS);
    localparam int unsigned PW = $clog2(BLK_DEPTH);

    // Element WORDS-1 holds the first word, so the packed vector is MSB-first.
    logic [WORDS-1:0][WORD_W-1:0] asm_q, asm_d;
    logic [BW-1:0]                mem_q [BLK_DEPTH];
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]                level_q, level_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         ovf_q, ovf_d;
    logic                         last_word, full, accept, drop, push, pop;

    always_comb begin
        last_word = (cnt_q == CW'(WORDS - 1));
        // Stall only when the word about to complete a block has nowhere to go;
        // a pop in the same cycle does not help, keeping out_ready off this path.
        full      = last_word && (level_q == LW'(BLK_DEPTH));
        accept    = wr_en && !full && !flush;
        drop      = wr_en && full && !flush;
        push      = accept && last_word;
        pop       = out_ready && (level_q != '0);

        asm_d = asm_q;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (cnt_q == CW'(i)) asm_d[WORDS-1-i] = wr_data;
        end

        cnt_d = cnt_q;
        if (flush || push) cnt_d = '0;
        else if (accept)   cnt_d = cnt_q + CW'(1);

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        ovf_d = ovf_q;
        if (drop)              ovf_d = 1'b1;
        else if (overflow_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) asm_q <= asm_d;
        if (push)   mem_q[wr_ptr_q] <= asm_d;
    end

    assign in_ready  = !full;
    assign out_valid = (level_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level     = level_q;
    assign word_cnt  = cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_block_assembler.sv
// Bench for block_assembler: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_block_assembler;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned WORDS     = 4;
    localparam int unsigned BLK_DEPTH = 4;
    localparam int unsigned BW        = WORD_W * WORDS;
    localparam int unsigned LW        = $clog2(BLK_DEPTH + 1);
    localparam int unsigned CW        = $clog2(WORDS);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr_en = 1'b0;
    logic [WORD_W-1:0] wr_data = '0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic [BW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [LW-1:0]     level;
    logic [CW-1:0]     word_cnt;
    logic              overflow;
    logic              overflow_clr = 1'b0;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    block_assembler #(.WORD_W(WORD_W), .WORDS(WORDS), .BLK_DEPTH(BLK_DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .in_ready(in_ready), .flush(flush), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .level(level),
        .word_cnt(word_cnt), .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of finished blocks and a queue of pending words.
    logic [BW-1:0]     mq [$];
    logic [WORD_W-1:0] mp [$];
    bit                movf = 1'b0;
    bit                m_full, m_pop, m_drop;

    function automatic logic [BW-1:0] pack_words();
        logic [BW-1:0] b = '0;
        foreach (mp[i]) b = (b << WORD_W) | BW'(mp[i]);
        return b;
    endfunction

    function automatic bit model_full();
        return (mp.size() == WORDS - 1) && (mq.size() == BLK_DEPTH);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            mp.delete();
            movf = 1'b0;
        end else begin
            m_full = model_full();
            m_pop  = out_ready && (mq.size() != 0);
            m_drop = wr_en && m_full && !flush;
            if (m_pop) void'(mq.pop_front());
            if (flush) mp.delete();
            else if (wr_en && !m_full) begin
                mp.push_back(wr_data);
                if (mp.size() == WORDS) begin
                    mq.push_back(pack_words());
                    mp.delete();
                end
            end
            if (m_drop)            movf = 1'b1;
            else if (overflow_clr) movf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_out_valid", BW'(out_valid), BW'(mq.size() != 0));
            chk("cmp_out_data", out_data, (mq.size() != 0) ? mq[0] : '0);
            chk("cmp_level", BW'(level), BW'(mq.size()));
            chk("cmp_word_cnt", BW'(word_cnt), BW'(mp.size()));
            chk("cmp_in_ready", BW'(in_ready), BW'(!model_full()));
            chk("cmp_overflow", BW'(overflow), BW'(movf));
        end
    end

    // Apply one cycle of inputs, then settle just past the rising edge.
    task automatic cyc(input logic we, input logic [WORD_W-1:0] d, input logic fl,
                       input logic orr, input logic clr);
        @(negedge clk);
        wr_en = we; wr_data = d; flush = fl; out_ready = orr; overflow_clr = clr;
        @(posedge clk);
        #1;
    endtask

    logic [BW-1:0] got [$];
    logic [BW-1:0] expb;
    bit            hi_ready;

    initial begin
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("reset_in_ready", BW'(in_ready), BW'(1));
        chk("reset_out_data", out_data, '0);

        // Basic block
        cyc(1, 32'h00112233, 0, 0, 0);
        cyc(1, 32'h44556677, 0, 0, 0);
        cyc(1, 32'h8899AABB, 0, 0, 0);
        cyc(1, 32'hCCDDEEFF, 0, 0, 0);
        chk("basic_valid", BW'(out_valid), BW'(1));
        chk("basic_data", out_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        chk("basic_level", BW'(level), BW'(1));
        chk("basic_wcnt", BW'(word_cnt), BW'(0));
        cyc(0, 0, 0, 1, 0);

        // Fill and back-pressure, with overflow clear cases
        for (int i = 0; i < 19; i++) cyc(1, $urandom, 0, 0, 0);
        chk("fill_level", BW'(level), BW'(4));
        chk("fill_wcnt", BW'(word_cnt), BW'(3));
        chk("fill_in_ready", BW'(in_ready), BW'(0));
        cyc(1, 32'hDEAD0001, 0, 0, 0);
        chk("drop_ovf", BW'(overflow), BW'(1));
        chk("drop_wcnt", BW'(word_cnt), BW'(3));
        cyc(0, 0, 0, 0, 1);
        chk("clr_alone", BW'(overflow), BW'(0));
        cyc(1, 32'hDEAD0002, 0, 0, 1);
        chk("clr_vs_drop", BW'(overflow), BW'(1));
        cyc(0, 0, 0, 1, 0);
        chk("pop_level", BW'(level), BW'(3));
        chk("pop_in_ready", BW'(in_ready), BW'(1));
        cyc(1, 32'h12345678, 0, 0, 0);
        chk("refill_level", BW'(level), BW'(4));
        chk("refill_wcnt", BW'(word_cnt), BW'(0));
        repeat (4) cyc(0, 0, 0, 1, 1);
        chk("drain_level", BW'(level), BW'(0));
        chk("drain_ovf", BW'(overflow), BW'(0));

        // Streaming
        for (int i = 0; i < 16; i++) begin
            cyc(1, WORD_W'(i), 0, 1, 0);
            if (level > 1) chk("stream_level_max", BW'(level), BW'(1));
            if (overflow)  chk("stream_ovf", BW'(overflow), BW'(0));
            if (out_valid) got.push_back(out_data);
        end
        cyc(0, 0, 0, 1, 0);
        chk("stream_count", BW'(got.size()), BW'(4));
        for (int k = 0; k < 4; k++) begin
            expb = {WORD_W'(4*k), WORD_W'(4*k+1), WORD_W'(4*k+2), WORD_W'(4*k+3)};
            if (k < got.size()) chk("stream_block", got[k], expb);
        end

        // Flush
        cyc(1, 32'hA, 0, 0, 0);
        cyc(1, 32'hB, 0, 0, 0);
        chk("pre_flush_wcnt", BW'(word_cnt), BW'(2));
        cyc(1, 32'hC, 1, 0, 0);
        chk("flush_wcnt", BW'(word_cnt), BW'(0));
        chk("flush_ovf", BW'(overflow), BW'(0));
        for (int i = 1; i <= 4; i++) cyc(1, WORD_W'(i), 0, 0, 0);
        chk("flush_data", out_data, 128'h00000001_00000002_00000003_00000004);
        chk("flush_level", BW'(level), BW'(1));

        // Asynchronous reset mid-cycle
        for (int i = 0; i < 6; i++) cyc(1, $urandom, 0, 0, 0);
        chk("prereset_level", BW'(level), BW'(2));
        chk("prereset_wcnt", BW'(word_cnt), BW'(2));
        #1 reset = 1'b0;
        #1;
        chk("areset_valid", BW'(out_valid), BW'(0));
        chk("areset_level", BW'(level), BW'(0));
        chk("areset_wcnt", BW'(word_cnt), BW'(0));
        chk("areset_ovf", BW'(overflow), BW'(0));
        chk("areset_data", out_data, '0);
        @(negedge clk);
        wr_en = 1'b0; out_ready = 1'b0;
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk("release_in_ready", BW'(in_ready), BW'(1));

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            hi_ready = ((n / 60) % 2) == 1;
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 24) == 0,
                hi_ready ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0),
                $urandom_range(0, 15) == 0);
        end
        cyc(0, 0, 0, 0, 0);

        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
